// File: rtl/thcattus_frame_packer_if.sv
// Sample-in / AXI-Stream frame-out bundle for the frame packer.
// The master modport is the packer's view; the slave modport is the view of its neighbours.
interface thcattus_frame_packer_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                        sample_valid;
    logic [31:0]                 sample_runup;
    logic [15:0]                 sample_residue;
    logic [7:0]                  sample_flags;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic [95:0]                 m_axis_tdata;
    logic [7:0]                  drop_count;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    modport master (
        input  sample_valid, sample_runup, sample_residue, sample_flags, m_axis_tready,
        output m_axis_tvalid, m_axis_tdata, drop_count, fifo_level
    );

    modport slave (
        output sample_valid, sample_runup, sample_residue, sample_flags, m_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, drop_count, fifo_level
    );
endinterface

// File: rtl/thcattus_frame_packer.sv
// Packs conversion results into 12-byte checksummed frames; sample at edge N is queued at edge N+1.
// Never stalls the sampler: a result that finds the FIFO full (and no pop that cycle) is dropped and counted.
module thcattus_frame_packer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         DATA_WIDTH = 12
) (
    input  logic                    axis_aclk,
    input  logic                    axis_arestn,
    thcattus_frame_packer_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    if (DATA_WIDTH != 12) begin : g_bad_width
        $error("thcattus_frame_packer: DATA_WIDTH must be 12");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("thcattus_frame_packer: FIFO_DEPTH must be a power of 2, at least 2");
    end

    logic          r_s1_vld;
    logic [7:0]    r_s1_seq;
    logic [7:0]    r_s1_flags;
    logic [31:0]   r_s1_runup;
    logic [15:0]   r_s1_residue;
    logic [7:0]    r_seq;
    logic [7:0]    r_drop_cnt;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [95:0]   r_mem [FIFO_DEPTH];

    logic [79:0]   w_body;
    logic [7:0]    w_sum;
    logic [7:0]    w_xor;
    logic [95:0]   w_frame;
    logic          w_vld;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // Byte 9 carries the drop count as it stands when this frame is formed.
    assign w_body = {r_drop_cnt, r_s1_residue, r_s1_runup, r_s1_flags, r_s1_seq, SYNC_BYTE};

    always_comb begin
        w_sum = 8'h00;
        w_xor = 8'h00;
        for (int k = 0; k < 10; k++) begin
            w_sum = w_sum + w_body[8*k +: 8];
            w_xor = w_xor ^ w_body[8*k +: 8];
        end
    end

    assign w_frame = {w_xor ^ w_sum, w_sum, w_body};

    assign w_vld  = (r_level != '0);
    assign w_pop  = w_vld && bus.m_axis_tready;
    // A pop frees the slot this same edge, so a full FIFO can still take the frame.
    assign w_push = r_s1_vld && ((r_level != LW'(FIFO_DEPTH)) || w_pop);
    assign w_drop = r_s1_vld && !w_push;

    always_ff @(posedge axis_aclk or negedge axis_arestn) begin
        if (!axis_arestn) begin
            r_s1_vld     <= 1'b0;
            r_s1_seq     <= 8'h00;
            r_s1_flags   <= 8'h00;
            r_s1_runup   <= 32'h0;
            r_s1_residue <= 16'h0;
            r_seq        <= 8'h00;
        end else begin
            r_s1_vld <= bus.sample_valid;
            if (bus.sample_valid) begin
                r_s1_seq     <= r_seq;
                r_s1_flags   <= bus.sample_flags;
                r_s1_runup   <= bus.sample_runup;
                r_s1_residue <= bus.sample_residue;
                r_seq        <= r_seq + 8'd1;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_arestn) begin
        if (!axis_arestn) begin
            r_drop_cnt <= 8'h00;
        end else if (w_push) begin
            r_drop_cnt <= 8'h00;
        end else if (w_drop && r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_arestn) begin
        if (!axis_arestn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_level <= r_level + LW'(1);
            else if (!w_push && w_pop) r_level <= r_level - LW'(1);
        end
    end

    // Storage needs no reset: the level gates everything read out of it.
    always_ff @(posedge axis_aclk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_frame;
    end

    assign bus.m_axis_tvalid = w_vld;
    assign bus.m_axis_tdata  = w_vld ? r_mem[r_rd_ptr] : 96'h0;
    assign bus.drop_count    = r_drop_cnt;
    assign bus.fifo_level    = r_level;
endmodule

// File: doc/thcattus_frame_packer.md
Name: thcattus_frame_packer

Overview:
Sits directly upstream of the multi-byte UART transmitter. Converts each multi-slope conversion result (run-up count, residue, flags) into a fixed 12-byte AXI-Stream frame with sync byte, sequence number, drop counter and two checksums. A small FIFO absorbs UART backpressure. Results arriving while the FIFO is full are dropped and counted, never stalled.

Parameters:
FIFO_DEPTH, 4, frame FIFO entries; power of 2, minimum 2.
SYNC_BYTE, 8'hA5, value of frame byte 0.
DATA_WIDTH, 12, frame width in bytes; fixed at 12; any other value is a configuration error.

Ports:
axis_aclk  in  1  clock
axis_arestn  in  1  reset, asynchronous assert, active-low
sample_valid  in  1  one-cycle strobe; sample fields valid
sample_runup  in  32  signed run-up count
sample_residue  in  16  run-down residue
sample_flags  in  8  status flags, passed through
m_axis_tvalid  out  1  frame available
m_axis_tready  in  1  downstream accepts
m_axis_tdata  out  96  frame; byte k at [8k+7:8k]; byte 0 is transmitted first
drop_count  out  8  pending drop count, saturating
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: one clock, axis_aclk. Reset is asynchronous and active-low on axis_arestn. While low:
  - FIFO emptied; m_axis_tvalid=0; m_axis_tdata=0.
  - sequence counter=0; drop_count=0; fifo_level=0; S1 stage invalid.
- Reset mid-frame discards all queued and in-flight frames. No partial state survives.
- Stage S1: on a clock edge with sample_valid=1, register the fields and the current seq into S1, then seq increments mod 256. S1 never stalls. It is consumed on the next edge by a write or a drop.
- Stage S2 (frame formation, combinational from S1 plus drop_count):
  - byte0 = SYNC_BYTE
  - byte1 = seq
  - byte2 = flags
  - bytes3..6 = runup, little-endian
  - bytes7..8 = residue, little-endian
  - byte9 = drop_count
  - byte10 = sum of bytes0..9 mod 256
  - byte11 = XOR of bytes0..10
- Write rule: a valid S1 is written when level<FIFO_DEPTH, or when level==FIFO_DEPTH and a pop occurs in the same cycle.
  - On write: drop_count clears to 0, because it was just reported in byte9.
  - Otherwise the frame is dropped and drop_count increments, saturating at 255.
  - seq is not rewound, so the gap is visible downstream.
- Latency: sample_valid at edge N, frame written at edge N+1. With an empty FIFO, m_axis_tvalid is high after edge N+1.
- Output handshake:
  - Pop occurs when m_axis_tvalid && m_axis_tready.
  - m_axis_tvalid = (level!=0).
  - m_axis_tdata shows the FIFO head and is stable while tvalid && !tready.
  - tvalid never drops without a pop.
- Simultaneous push and pop: level unchanged. Works at empty (new frame becomes head next cycle; no same-cycle bypass) and at full.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Level is held separately to distinguish full from empty.
- sample_valid on back-to-back cycles is legal. One frame per cycle may be generated.

Test Plan:
- Reset, then runup=32'h1, residue=16'h2, flags=0, tready=1 -> after 2 edges tvalid=1, tdata=96'h0EA8_0000_0200_0000_0100_00A5. Popped the same cycle; level returns to 0.
- Hold tready=0, send 6 samples on consecutive cycles (FIFO_DEPTH=4) -> level=4, drop_count=2, head seq=0 and unchanged. Then tready=1, one more sample -> frames seq 0,1,2,3 drain in order; the new frame has seq=6, byte9=2; drop_count reads 0 after its write.
- tready=0, fill to 4, then assert a sample in the same cycle as a pop -> frame accepted, level stays 4, drop_count stays 0.
- tready=0 with 300 samples -> drop_count saturates at 255, and seq wraps 255→0. On release, the next queued frame carries byte9=255.
- Random tready toggling, 1000 random samples -> every frame's checksums verify, tdata is stable while stalled, seq is monotonic mod 256 except for gaps equal to the reported drop counts.
- Assert axis_arestn low asynchronously mid-stream with level=3 -> tvalid falls immediately. After release the first frame has seq=0 and byte9=0.
